// File: rtl/lsu_pkg.sv
// Shared constants and state encoding for the load/store memory master.
package lsu_pkg;

  localparam int DEF_MEM_BYTES = 1024;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RMW_READ = 3'd2,
    S_WRITE    = 3'd3,
    S_RESP     = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: load extraction/extension and store merge.
import lsu_pkg::*;

module lsu_byte_lane (
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ldata,
  output logic [31:0] o_mdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte/halfword and extend it according to funct3.
  always_comb begin
    w_byte  = i_word[{i_lane, 3'b000} +: 8];
    w_half  = i_word[{i_lane[1], 4'b0000} +: 16];
    o_ldata = 32'h0;
    case (i_funct3)
      F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
      F3_W:    o_ldata = i_word;
      F3_BU:   o_ldata = {24'h0, w_byte};
      F3_HU:   o_ldata = {16'h0, w_half};
      default: o_ldata = 32'h0;
    endcase
  end

  // Overlay the store data onto the old word; no byte enables on the memory.
  always_comb begin
    o_mdata = i_word;
    case (i_funct3)
      F3_B:    o_mdata[{i_lane, 3'b000} +: 8]     = i_wdata[7:0];
      F3_H:    o_mdata[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      F3_W:    o_mdata = i_wdata;
      default: o_mdata = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-addressed memory without byte enables.
// Sub-word stores are done as read-modify-write; bad accesses fault early.
import lsu_pkg::*;

module lsu_mem_master #(
  parameter int          MEM_BYTES  = DEF_MEM_BYTES,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  r_state, w_next;
  logic        r_store, r_fault;
  logic [2:0]  r_f3;
  logic [31:0] r_addr, r_wdata, r_merged, r_rdata;

  logic        w_accept, w_f3_ok, w_is_h, w_is_w, w_misal, w_fault;
  logic [31:0] w_lim, w_ldata, w_mdata;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // Fault decode on the raw request, evaluated in the acceptance cycle.
  always_comb begin
    w_f3_ok = req_store ? (req_funct3 <= F3_W)
                        : (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    w_is_h  = (req_funct3[1:0] == 2'd1);
    w_is_w  = (req_funct3[1:0] == 2'd2);
    w_misal = (w_is_h && req_addr[0]) || (w_is_w && (req_addr[1:0] != 2'b00));
    // Last legal start address: word accesses must fit entirely in memory.
    w_lim   = w_is_w ? 32'(MEM_BYTES - 4) : 32'(MEM_BYTES - 1);
    w_fault = !w_f3_ok || w_misal || (req_addr > w_lim);
  end

  lsu_byte_lane u_lane (
    .i_funct3 (r_f3),
    .i_lane   (r_addr[1:0]),
    .i_word   (mem_rdata),
    .i_wdata  (r_wdata),
    .o_ldata  (w_ldata),
    .o_mdata  (w_mdata)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and memory/response outputs, all decoded from state.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_fault = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = RESET_ADDR;
    mem_wdata  = 32'h0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (w_fault)                w_next = S_RESP;
          else if (!req_store)        w_next = S_LOAD;
          else if (req_funct3 == F3_W) w_next = S_WRITE;
          else                        w_next = S_RMW_READ;
        end
      end
      S_LOAD: begin
        mem_addr = {r_addr[31:2], 2'b00};
        w_next   = S_RESP;
      end
      S_RMW_READ: begin
        mem_addr = {r_addr[31:2], 2'b00};
        w_next   = S_WRITE;
      end
      S_WRITE: begin
        mem_write = 1'b1;
        mem_addr  = {r_addr[31:2], 2'b00};
        mem_wdata = r_merged;
        w_next    = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_fault = r_fault;
        resp_rdata = (r_store || r_fault) ? 32'h0 : r_rdata;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, load result capture and store-word merge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_store  <= 1'b0;
      r_fault  <= 1'b0;
      r_f3     <= 3'd0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_merged <= 32'h0;
      r_rdata  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_store  <= req_store;
          r_fault  <= w_fault;
          r_f3     <= req_funct3;
          r_addr   <= req_addr;
          r_wdata  <= req_wdata;
          r_merged <= req_wdata;  // final for SW, replaced for SB/SH
          r_rdata  <= 32'h0;
        end
        S_LOAD:     r_rdata  <= w_ldata;
        S_RMW_READ: r_merged <= w_mdata;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-addressed data memory port: memory write enable, word address, write data, and combinational read data.
- Accepts one RV32I load or store per request from the core datapath.
- Performs byte-lane extraction with sign or zero extension for loads.
- Memory has no byte enables, so SB and SH are done as read-modify-write.
- Rejects misaligned, out-of-range and illegal-funct3 accesses with a fault response and issues no memory write.

Parameters:
- MEM_BYTES, 1024: size of the memory in bytes. Any access with addr >= MEM_BYTES faults.
- RESET_ADDR, 0: value driven on mem_addr while idle or in reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- req_valid  in  1  core presents a request.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high at a rising edge.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte or low halfword used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and faults.
- resp_fault  out  1  access rejected; valid together with resp_valid.
- mem_write  out  1  memory write enable (MemWrite).
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational memory read data.

Behaviour:
- Reset (asynchronous): state=IDLE. req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_write=0, mem_addr=RESET_ADDR, mem_wdata=0. All latched request registers are cleared.
- Reset mid-operation: the operation is abandoned and no resp_valid is produced. mem_write falls immediately. A store not yet past its WRITE rising edge leaves memory unchanged.
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- Acceptance cycle C0, from IDLE: latch store, funct3, addr and wdata. Next state:
  - fault condition -> RESP with fault=1;
  - load -> LOAD;
  - SW -> WRITE, merged word = req_wdata;
  - SB/SH -> RMW_READ.
- Fault conditions, any of:
  - illegal funct3: load funct3 of 3, 6 or 7; store funct3 greater than 2;
  - halfword access with addr[0]=1;
  - word access with addr[1:0] not 0;
  - addr > MEM_BYTES-4 for a word access, or addr >= MEM_BYTES otherwise.
- LOAD, cycle C1: mem_addr = aligned address. At the end of C1, mem_rdata is extracted and extended, then registered:
  - byte lane = addr[1:0], halfword lane = addr[1];
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Next state is RESP; resp_valid is high in C2.
- RMW_READ, cycle C1: mem_addr driven. At the end of C1, register the merged word = mem_rdata with the target lane replaced by req_wdata[7:0] (SB) or req_wdata[15:0] (SH). Next state is WRITE.
- WRITE: mem_write=1, mem_addr = aligned address, mem_wdata = merged word, for exactly one cycle. Memory updates at the end of this cycle. Next state is RESP.
- RESP: resp_valid=1 for one cycle; resp_rdata and resp_fault are valid in this cycle. Next state is IDLE.
- Outside RESP, resp_valid, resp_rdata and resp_fault are 0. There is no response backpressure: the core must consume the pulse.
- Latency from C0 to the resp_valid cycle:
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles;
  - fault: 1 cycle.
- Throughput: the next request can be accepted no earlier than the cycle after RESP.
- req_valid and the other request inputs are ignored whenever req_ready=0; changing them mid-operation has no effect.
- mem_write is 0 in every state except WRITE, including in fault paths.
- mem_addr returns to RESET_ADDR in IDLE and RESP.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5);
  - the state encoding;
  - the MEM_BYTES default.
- One sub-module, lsu_byte_lane: purely combinational. Its load path takes (funct3, addr[1:0], word) and returns the extended result. Its store path takes (funct3, addr[1:0], old word, wdata) and returns the merged word.

Test Plan:
- Preload word 0x10 = 0x8899AABB. Expected loads:
  - LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088;
  - LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB; LW 0x10 -> 0x8899AABB;
  - each has resp_valid 2 cycles after acceptance, fault=0, and mem_write never high.
- SB 0x11 with wdata 0x12345677 -> one RMW_READ cycle, then one mem_write pulse with mem_wdata=0x889977BB, resp_valid 3 cycles after acceptance. A subsequent LW 0x10 returns 0x889977BB.
- SW 0x3FC with 0xDEADBEEF -> mem_write for exactly 1 cycle; LW 0x3FC then returns 0xDEADBEEF. With req_valid held high throughout, req_ready=0 from C1 to RESP and the held request is accepted only after RESP.
- Faults, each giving resp_valid 1 cycle after acceptance with resp_fault=1, resp_rdata=0, mem_write never high and memory unchanged:
  - SH 0x11;
  - LW 0x3FE;
  - LW 0x400;
  - load funct3=3.
- Assert reset during the WRITE cycle of SH 0x10 -> mem_write drops within the same cycle and word 0x10 is unchanged. There is no resp_valid, req_ready=1 during reset, and the next request after deassertion completes normally.
